// File: rtl/fft_stream_ctrl_if.sv
// Bus bundle for fft_stream_ctrl: sample stream in, bin stream out, core RAM and control ports.
// The controller connects through the slave modport; the surrounding system uses master.
interface fft_stream_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int N_LOG2 = 11,
    parameter int BANKS  = 4
);
    localparam int ADDR_W = N_LOG2 - $clog2(BANKS);

    logic                        iS_VALID;
    logic                        oS_READY;
    logic [DATA_W-1:0]           iS_DATA;
    logic                        iS_LAST;
    logic                        oM_VALID;
    logic                        iM_READY;
    logic [DATA_W:0]             oM_DATA;
    logic [N_LOG2-1:0]           oM_INDEX;
    logic                        oM_LAST;
    logic [BANKS-1:0]            oWE;
    logic [ADDR_W-1:0]           oADDR_WR;
    logic [DATA_W-1:0]           oDATA_WR;
    logic [ADDR_W-1:0]           oADDR_RD;
    logic [BANKS*(DATA_W+1)-1:0] iDATA_RD;
    logic                        oCORE_START;
    logic                        iCORE_RDY;
    logic                        oBUSY;
    logic                        oERR_LEN;

    modport slave (
        input  iS_VALID, iS_DATA, iS_LAST, iM_READY, iDATA_RD, iCORE_RDY,
        output oS_READY, oM_VALID, oM_DATA, oM_INDEX, oM_LAST, oWE, oADDR_WR,
               oDATA_WR, oADDR_RD, oCORE_START, oBUSY, oERR_LEN
    );

    modport master (
        output iS_VALID, iS_DATA, iS_LAST, iM_READY, iDATA_RD, iCORE_RDY,
        input  oS_READY, oM_VALID, oM_DATA, oM_INDEX, oM_LAST, oWE, oADDR_WR,
               oDATA_WR, oADDR_RD, oCORE_START, oBUSY, oERR_LEN
    );
endinterface

// File: rtl/fft_stream_ctrl.sv
// Streaming load/unload controller for the banked radix-4 FFT core: scatters a frame into the
// banks, kicks the core, waits for done, then streams result bins out through a 2-entry skid.
module fft_stream_ctrl #(
    parameter int DATA_W        = 16,
    parameter int N_LOG2        = 11,
    parameter int BANKS         = 4,
    parameter int OUT_DIGIT_REV = 0
) (
    input  logic             iCLK,
    input  logic             iRESET,
    fft_stream_ctrl_if.slave bus
);
    localparam int BANK_W = $clog2(BANKS);
    localparam int RES_W  = DATA_W + 1;
    localparam logic [N_LOG2-1:0] LAST_IDX = '1;

    typedef enum logic [2:0] {LOAD, PAD, START, RUN, UNLOAD} state_t;
    typedef struct packed {
        logic [RES_W-1:0]  data;
        logic [N_LOG2-1:0] idx;
        logic              last;
    } bin_t;

    state_t            state;
    logic [N_LOG2-1:0] k, rd_m, rd_idx_q, rd_j;
    logic [BANK_W-1:0] rd_bank_q;
    logic              rd_done, rvld_q, rdy_q;
    logic [1:0]        ign, occ, occ_mid;
    logic              accept, pop, issue;
    bin_t              out_q, skid_q, ent;

    generate
        if (OUT_DIGIT_REV != 0) begin : g_rev
            for (genvar d = 0; d < N_LOG2/2; d++) begin : g_dig
                assign rd_j[2*d +: 2] = rd_m[N_LOG2-2-2*d +: 2];
            end
        end else begin : g_nat
            assign rd_j = rd_m;
        end
    endgenerate

    assign bus.oADDR_RD = rd_j[N_LOG2-1:BANK_W];
    assign bus.oM_DATA  = out_q.data;
    assign bus.oM_INDEX = out_q.idx;
    assign bus.oM_LAST  = out_q.last;

    // A read is launched only if everything already owed to the skid still fits after this pop.
    always_comb begin
        accept  = bus.iS_VALID & bus.oS_READY;
        pop     = bus.oM_VALID & bus.iM_READY;
        occ_mid = occ - {1'b0, pop};
        issue   = (state == UNLOAD) && !rd_done && ((occ_mid + {1'b0, rvld_q}) < 2'd2);
        ent     = '{data: bus.iDATA_RD[rd_bank_q*RES_W +: RES_W],
                    idx:  rd_idx_q,
                    last: rd_idx_q == LAST_IDX};
    end

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            state           <= LOAD;
            k               <= '0;
            rd_m            <= '0;
            rd_done         <= 1'b0;
            rd_idx_q        <= '0;
            rd_bank_q       <= '0;
            rvld_q          <= 1'b0;
            rdy_q           <= 1'b0;
            ign             <= '0;
            occ             <= '0;
            out_q           <= '0;
            skid_q          <= '0;
            bus.oS_READY    <= 1'b1;
            bus.oM_VALID    <= 1'b0;
            bus.oWE         <= '0;
            bus.oADDR_WR    <= '0;
            bus.oDATA_WR    <= '0;
            bus.oCORE_START <= 1'b0;
            bus.oBUSY       <= 1'b0;
            bus.oERR_LEN    <= 1'b0;
        end else begin
            bus.oWE         <= '0;
            bus.oCORE_START <= 1'b0;
            bus.oERR_LEN    <= 1'b0;
            rdy_q           <= bus.iCORE_RDY;

            rvld_q <= issue;
            if (issue) begin
                rd_idx_q  <= rd_m;
                rd_bank_q <= rd_j[BANK_W-1:0];
                if (rd_m == LAST_IDX) rd_done <= 1'b1;
                else                  rd_m    <= rd_m + 1'b1;
            end

            // Skid: pop shifts the spare into the head, a returning read fills the first free slot.
            if (pop) out_q <= skid_q;
            if (rvld_q) begin
                if (occ_mid == 2'd0) out_q  <= ent;
                else                 skid_q <= ent;
            end
            occ          <= occ_mid + {1'b0, rvld_q};
            bus.oM_VALID <= (occ_mid + {1'b0, rvld_q}) != 2'd0;

            case (state)
                LOAD: if (accept) begin
                    bus.oWE      <= {{(BANKS-1){1'b0}}, 1'b1} << k[BANK_W-1:0];
                    bus.oADDR_WR <= k[N_LOG2-1:BANK_W];
                    bus.oDATA_WR <= bus.iS_DATA;
                    if (k == LAST_IDX) begin
                        bus.oERR_LEN <= !bus.iS_LAST;
                        state        <= START;
                        k            <= '0;
                        bus.oS_READY <= 1'b0;
                        bus.oBUSY    <= 1'b1;
                    end else begin
                        k <= k + 1'b1;
                        if (bus.iS_LAST) begin
                            bus.oERR_LEN <= 1'b1;
                            state        <= PAD;
                            bus.oS_READY <= 1'b0;
                            bus.oBUSY    <= 1'b1;
                        end
                    end
                end
                PAD: begin
                    bus.oWE      <= {{(BANKS-1){1'b0}}, 1'b1} << k[BANK_W-1:0];
                    bus.oADDR_WR <= k[N_LOG2-1:BANK_W];
                    bus.oDATA_WR <= '0;
                    if (k == LAST_IDX) begin
                        state <= START;
                        k     <= '0;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                START: begin
                    bus.oCORE_START <= 1'b1;
                    ign             <= 2'd2;
                    state           <= RUN;
                end
                // Done is a level that may still be high from the last frame; only a fresh rise counts.
                RUN: begin
                    if (ign != 2'd0)                         ign   <= ign - 2'd1;
                    else if (bus.iCORE_RDY && !rdy_q)        state <= UNLOAD;
                end
                UNLOAD: if (pop && bus.oM_LAST) begin
                    state        <= LOAD;
                    rd_m         <= '0;
                    rd_done      <= 1'b0;
                    bus.oS_READY <= 1'b1;
                    bus.oBUSY    <= 1'b0;
                end
                default: state <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_fft_stream_ctrl.sv
// Directed bench for fft_stream_ctrl: natural-order and digit-reversed instances share stimulus,
// each with its own bank RAM model; expected bins come from a frame-level model of the samples.
module tb_fft_stream_ctrl;
    localparam int DW = 16, NL = 4, NB = 4, N = 16, RW = 17;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          s_valid, s_last, m_ready, core_rdy, clr_mem, stuck, toggle;
    logic [DW-1:0] s_data;

    fft_stream_ctrl_if #(.DATA_W(DW), .N_LOG2(NL), .BANKS(NB)) ifc0 ();
    fft_stream_ctrl_if #(.DATA_W(DW), .N_LOG2(NL), .BANKS(NB)) ifc1 ();

    fft_stream_ctrl #(.DATA_W(DW), .N_LOG2(NL), .BANKS(NB), .OUT_DIGIT_REV(0)) dut0 (
        .iCLK(clk), .iRESET(rst_n), .bus(ifc0.slave));
    fft_stream_ctrl #(.DATA_W(DW), .N_LOG2(NL), .BANKS(NB), .OUT_DIGIT_REV(1)) dut1 (
        .iCLK(clk), .iRESET(rst_n), .bus(ifc1.slave));

    logic [NB*RW-1:0] rd [2];
    assign ifc0.iS_VALID = s_valid;  assign ifc1.iS_VALID = s_valid;
    assign ifc0.iS_DATA  = s_data;   assign ifc1.iS_DATA  = s_data;
    assign ifc0.iS_LAST  = s_last;   assign ifc1.iS_LAST  = s_last;
    assign ifc0.iM_READY = m_ready;  assign ifc1.iM_READY = m_ready;
    assign ifc0.iCORE_RDY = core_rdy; assign ifc1.iCORE_RDY = core_rdy;
    assign ifc0.iDATA_RD = rd[0];    assign ifc1.iDATA_RD = rd[1];

    logic [1:0]    mv, ml, sr, bz, st, er;
    logic [RW-1:0] md [2];
    logic [NL-1:0] mi [2];
    logic [NB-1:0] we [2];
    logic [1:0]    wa [2], ra [2];
    logic [DW-1:0] wd [2];
    assign mv = {ifc1.oM_VALID, ifc0.oM_VALID};
    assign ml = {ifc1.oM_LAST, ifc0.oM_LAST};
    assign sr = {ifc1.oS_READY, ifc0.oS_READY};
    assign bz = {ifc1.oBUSY, ifc0.oBUSY};
    assign st = {ifc1.oCORE_START, ifc0.oCORE_START};
    assign er = {ifc1.oERR_LEN, ifc0.oERR_LEN};
    assign md[0] = ifc0.oM_DATA;  assign md[1] = ifc1.oM_DATA;
    assign mi[0] = ifc0.oM_INDEX; assign mi[1] = ifc1.oM_INDEX;
    assign we[0] = ifc0.oWE;      assign we[1] = ifc1.oWE;
    assign wa[0] = ifc0.oADDR_WR; assign wa[1] = ifc1.oADDR_WR;
    assign ra[0] = ifc0.oADDR_RD; assign ra[1] = ifc1.oADDR_RD;
    assign wd[0] = ifc0.oDATA_WR; assign wd[1] = ifc1.oDATA_WR;

    // Stand-in for the core's transform: result word j = sign-extended sample j + 0x101.
    function automatic logic [RW-1:0] core_f(input logic [DW-1:0] x);
        return {x[DW-1], x} + 17'h101;
    endfunction

    logic [DW-1:0] mem [2][N];
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            for (int b = 0; b < NB; b++) begin
                rd[d][b*RW +: RW] <= core_f(mem[d][int'(ra[d])*NB + b]);
                if (clr_mem)     mem[d][int'(wa[d])*NB + b] <= 16'hAAAA;
                else if (we[d][b]) mem[d][int'(wa[d])*NB + b] <= wd[d];
            end
            if (clr_mem)
                for (int i = 0; i < N; i++) mem[d][i] <= 16'hAAAA;
        end
    end

    int checks = 0, errors = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, want);
        end
    endtask

    logic [RW-1:0] want_d [2][N];
    logic [RW-1:0] got [2][N];
    int cyc = 0, rise_cyc = -100;
    int pos [2], pops [2], nerr [2], nstart [2];
    logic prv_rdy = 1'b0;
    logic prv_v [2], hold [2];
    logic [22:0] snap [2];

    // Per-cycle compare: reset values, in-order bins, stall stability, first-bin latency.
    initial begin
        for (int d = 0; d < 2; d++) begin
            pos[d] = 0; pops[d] = 0; nerr[d] = 0; nstart[d] = 0; prv_v[d] = 0; hold[d] = 0;
        end
        forever begin
            @(negedge clk);
            cyc++;
            if (core_rdy && !prv_rdy) rise_cyc = cyc;
            prv_rdy = core_rdy;
            for (int d = 0; d < 2; d++) begin
                if (!rst_n) begin
                    chk("reset_outputs", {24'd0, mv[d], |we[d], st[d], er[d], |md[d], |mi[d], bz[d], sr[d]}, 32'h1);
                    pos[d] = 0; hold[d] = 0;
                end else begin
                    if (er[d]) nerr[d]++;
                    if (st[d]) nstart[d]++;
                    if (we[d] != '0) chk("we_onehot", $countones(we[d]), 1);
                    if (hold[d]) chk("stall_stable", {9'd0, mv[d], md[d], mi[d], ml[d]}, {9'd0, snap[d]});
                    if (mv[d] && !prv_v[d] && pos[d] == 0) chk("first_bin_latency", cyc - rise_cyc, 3);
                    if (mv[d] && m_ready) begin
                        chk("bin_index", mi[d], pos[d]);
                        chk("bin_data", md[d], want_d[d][pos[d]]);
                        chk("bin_last", ml[d], pos[d] == N-1);
                        got[d][pos[d]] = md[d];
                        pos[d] = (pos[d] == N-1) ? 0 : pos[d] + 1;
                        pops[d]++;
                    end
                    hold[d] = mv[d] && !m_ready;
                    snap[d] = {mv[d], md[d], mi[d], ml[d]};
                end
                prv_v[d] = mv[d];
            end
        end
    end

    // Core: done rises 20 cycles after start; in stuck mode done is left high, dropped, then re-raised.
    initial begin
        core_rdy = 1'b0;
        forever begin
            @(negedge clk);
            if (st[0] && rst_n) begin
                @(posedge clk); #1;
                if (stuck) begin
                    repeat (6) @(posedge clk);
                    #1 core_rdy = 1'b0;
                    repeat (3) @(posedge clk);
                    #1 core_rdy = 1'b1;
                end else begin
                    core_rdy = 1'b0;
                    repeat (19) @(posedge clk);
                    #1 core_rdy = 1'b1;
                end
            end
        end
    end

    initial begin
        int tcnt;
        logic [3:0] pat;
        pat = 4'b1001;
        tcnt = 0;
        m_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (toggle) begin m_ready = pat[tcnt % 4]; tcnt++; end
            else m_ready = 1'b1;
        end
    end

    task automatic load_frame(input int last_at, input logic [DW-1:0] base, input logic [DW-1:0] step,
                              input int nsamp);
        logic [DW-1:0] samp [N];
        for (int i = 0; i < N; i++) samp[i] = '0;
        clr_mem = 1'b1;
        @(posedge clk); #1;
        clr_mem = 1'b0;
        for (int k = 0; k < nsamp; k++) begin
            s_valid = 1'b1;
            s_data  = base + DW'(k) * step;
            s_last  = (k == last_at);
            @(negedge clk);
            chk("s_ready_load", sr, 2'b11);
            samp[k] = s_data;
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        for (int m = 0; m < N; m++) begin
            want_d[0][m] = core_f(samp[m]);
            want_d[1][m] = core_f(samp[(m % 4) * 4 + m / 4]);
        end
        @(negedge clk);
        chk("s_ready_drop", sr, 2'b00);
        chk("busy_after_load", bz, 2'b11);
    endtask

    task automatic run_frame(input int last_at, input logic [DW-1:0] base, input logic [DW-1:0] step,
                             input int nsamp, input int want_err);
        int p0, p1, e0, s0, to;
        @(posedge clk); #1;
        @(negedge clk);
        chk("idle_ready", {bz, sr}, 4'b0011);
        @(posedge clk); #1;
        p0 = pops[0]; p1 = pops[1]; e0 = nerr[0]; s0 = nstart[0];
        load_frame(last_at, base, step, nsamp);
        to = 0;
        while ((pops[0] - p0 < N || pops[1] - p1 < N) && to < 800) begin
            @(negedge clk);
            to++;
        end
        chk("frame_timeout", to < 800, 1);
        chk("bins_dut1", pops[1] - p1, N);
        chk("err_len_pulses", nerr[0] - e0, want_err);
        chk("core_start_pulses", nstart[0] - s0, 1);
        @(negedge clk);
        chk("ready_after_unload", {bz, sr}, 4'b0011);
    endtask

    initial begin
        int to, p0;
        s_valid = 0; s_last = 0; s_data = '0; clr_mem = 0; stuck = 0; toggle = 0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Samples 0..15, last on 15, output always ready.
        run_frame(15, 16'h0000, 16'h0001, N, 0);
        chk("lit_nat_m0", got[0][0], 17'h00101);
        chk("lit_nat_m15", got[0][15], 17'h00110);
        chk("lit_rev_m1_j4", got[1][1], 17'h00105);
        chk("lit_rev_m6_j9", got[1][6], 17'h0010a);

        // Negative samples with a 1,0,0,1 ready pattern.
        toggle = 1'b1;
        run_frame(15, 16'h8000, 16'h0123, N, 0);
        toggle = 1'b0;
        chk("lit_neg_m0", got[0][0], 17'h18101);

        // Early last at k=9: zero padding of 10..15.
        run_frame(9, 16'h1000, 16'h0001, 10, 1);
        chk("lit_pad_m9", got[0][9], 17'h0110a);
        chk("lit_pad_m12", got[0][12], 17'h00101);
        chk("lit_pad_rev_m4", got[1][4], 17'h01102);
        chk("lit_pad_rev_m3", got[1][3], 17'h00101);

        // Missing last; done already high at start so an edge is required.
        stuck = 1'b1;
        run_frame(-1, 16'h0400, 16'h0011, N, 1);
        stuck = 1'b0;

        // Reset in the middle of unloading.
        @(posedge clk); #1;
        p0 = pops[0];
        load_frame(15, 16'h2222, 16'h0101, N);
        to = 0;
        while (pops[0] - p0 < 7 && to < 800) begin @(negedge clk); to++; end
        chk("unload_reach_m7", to < 800, 1);
        @(posedge clk); #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_state", {mv, bz, sr}, 6'b000011);

        run_frame(15, 16'h7ff0, 16'h0003, N, 0);
        chk("lit_after_reset_m0", got[0][0], 17'h080f1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule
